io_ccff_config_ctrl: RTL and testbench

Configuration sequencer for the fabric's I/O tiles. Accepts the I/O bitstream as parallel words over a valid/ready stream and serializes it LSB-first into the I/O configuration-flip-flop chain (`ccff_head` → … → `ccff_tail`), gating the chain's shift enable. It holds the pads isolated through `IO_ISOL_N` until the chain is fully and cleanly loaded. It sits between the bitstream source (SoC config port) and the perimeter `io` logical tiles.

---
 rtl/io_cfg_pkg.sv | 23 ++
 rtl/ccff_word_serializer.sv | 53 +++++
 rtl/io_ccff_config_ctrl.sv | 116 +++++++++++
 tb/tb_io_ccff_config_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/io_cfg_pkg.sv
// Shared types and defaults for the I/O configuration-chain sequencer.
package io_cfg_pkg;

  localparam int DEF_CHAIN_LEN  = 80;
  localparam int DEF_WORD_W     = 8;
  localparam int DEF_TIMEOUT    = 255;
  localparam int DEF_SETTLE_CYC = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_SETTLE,
    ST_DONE,
    ST_ERR
  } io_cfg_state_e;

  // Width of a counter that must hold 0..max_val; never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Serializes one bitstream word LSB-first into the ccff chain and folds the
// bits leaving the chain tail into a running parity.
module ccff_word_serializer #(
  parameter int WORD_W = 8,
  parameter int CW     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] data,
  input  logic [CW-1:0]     bit_cnt,
  input  logic              clr_parity,
  input  logic              tail,
  output logic              head,
  output logic              shift_en,
  output logic              last_bit,
  output logic              tail_parity
);

  logic [WORD_W-1:0] sreg_p0;
  logic [CW-1:0]     left_p0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_en    <= 1'b0;
      tail_parity <= 1'b0;
    end else begin
      if (clr_parity)
        tail_parity <= 1'b0;
      else if (shift_en)
        tail_parity <= tail_parity ^ tail;
      if (load)
        shift_en <= 1'b1;
      else if (last_bit)
        shift_en <= 1'b0;
    end
  end

  // Word datapath: bits above bit_cnt are simply never shifted out.
  always_ff @(posedge clk) begin
    if (load) begin
      sreg_p0 <= data;
      left_p0 <= bit_cnt;
    end else if (shift_en) begin
      sreg_p0 <= sreg_p0 >> 1;
      left_p0 <= left_p0 - CW'(1);
    end
  end

  assign head     = shift_en & sreg_p0[0];
  assign last_bit = shift_en && (left_p0 == CW'(1));

endmodule

// File: rtl/io_ccff_config_ctrl.sv
// Loads the I/O tile ccff chain from a word stream and keeps the pads
// isolated until the whole chain has been shifted in and allowed to settle.
module io_ccff_config_ctrl
  import io_cfg_pkg::*;
#(
  parameter int CHAIN_LEN  = DEF_CHAIN_LEN,
  parameter int WORD_W     = DEF_WORD_W,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              IO_ISOL_N,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              tail_parity
);

  localparam int RW = cnt_w(CHAIN_LEN);
  localparam int IW = cnt_w(TIMEOUT);
  localparam int SW = cnt_w(SETTLE_CYC);
  localparam int CW = cnt_w(WORD_W);

  io_cfg_state_e state, state_nx;
  logic [RW-1:0] remaining;
  logic [IW-1:0] idle_cnt;
  logic [SW-1:0] settle_cnt;
  logic [CW-1:0] word_bits;
  logic          load, clr_parity, last_bit, idle_state;

  assign idle_state = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR);
  assign load       = (state == ST_LOAD) && cfg_valid;
  assign clr_parity = idle_state && start;
  // The final word of a chain that is not a multiple of WORD_W is truncated.
  assign word_bits  = (32'(remaining) < WORD_W) ? CW'(remaining) : CW'(WORD_W);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR:
        if (start) state_nx = ST_LOAD;
      ST_LOAD:
        if (cfg_valid)
          state_nx = ST_SHIFT;
        else if (32'(idle_cnt) == TIMEOUT - 1)
          state_nx = ST_ERR;
      ST_SHIFT:
        if (last_bit) begin
          if (remaining != RW'(1))
            state_nx = ST_LOAD;
          else
            state_nx = (SETTLE_CYC == 0) ? ST_DONE : ST_SETTLE;
        end
      ST_SETTLE:
        if (32'(settle_cnt) == SETTLE_CYC - 1) state_nx = ST_DONE;
      default:
        state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (!prog_rst_n) begin
      state      <= ST_IDLE;
      cfg_ready  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      IO_ISOL_N  <= 1'b0;
      remaining  <= '0;
      idle_cnt   <= '0;
      settle_cnt <= '0;
    end else begin
      state     <= state_nx;
      cfg_ready <= (state_nx == ST_LOAD);
      busy      <= (state_nx == ST_LOAD) || (state_nx == ST_SHIFT) || (state_nx == ST_SETTLE);
      done      <= (state_nx == ST_DONE);
      err       <= (state_nx == ST_ERR);
      IO_ISOL_N <= (state_nx == ST_DONE);
      if (clr_parity) begin
        remaining <= RW'(CHAIN_LEN);
        idle_cnt  <= '0;
      end
      if (state == ST_LOAD)
        idle_cnt <= cfg_valid ? '0 : idle_cnt + IW'(1);
      if (state == ST_SHIFT)
        remaining <= remaining - RW'(1);
      settle_cnt <= (state == ST_SETTLE) ? settle_cnt + SW'(1) : '0;
    end
  end

  ccff_word_serializer #(
    .WORD_W (WORD_W),
    .CW     (CW)
  ) u_ser (
    .clk         (prog_clk),
    .rst_n       (prog_rst_n),
    .load        (load),
    .data        (cfg_data),
    .bit_cnt     (word_bits),
    .clr_parity  (clr_parity),
    .tail        (ccff_tail),
    .head        (ccff_head),
    .shift_en    (ccff_shift_en),
    .last_bit    (last_bit),
    .tail_parity (tail_parity)
  );

endmodule

// File: tb/tb_io_ccff_config_ctrl.sv
// Directed bench: an 80-bit default controller and a 20-bit, no-settle one,
// each driving a behavioural ccff chain.
module tb_io_ccff_config_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start_a, valid_a, ready_a, head_a, sh_a, tail_a, isol_a, busy_a, done_a, err_a, par_a;
  logic start_b, valid_b, ready_b, head_b, sh_b, tail_b, isol_b, busy_b, done_b, err_b, par_b;
  logic [7:0]  data_a, data_b;
  logic [79:0] chain_a = '0;
  logic [19:0] chain_b = '0;
  logic        preload_req;
  logic [79:0] preload_val;
  int n_checks = 0;
  int n_fail   = 0;
  int cyc, words, pulses;

  localparam logic [79:0] STREAM = 80'h0A090807060504030201;

  io_ccff_config_ctrl dut_a (
    .prog_clk(clk), .prog_rst_n(rst_n), .start(start_a), .cfg_data(data_a),
    .cfg_valid(valid_a), .cfg_ready(ready_a), .ccff_head(head_a), .ccff_shift_en(sh_a),
    .ccff_tail(tail_a), .IO_ISOL_N(isol_a), .busy(busy_a), .done(done_a), .err(err_a),
    .tail_parity(par_a)
  );

  io_ccff_config_ctrl #(.CHAIN_LEN(20), .WORD_W(8), .TIMEOUT(255), .SETTLE_CYC(0)) dut_b (
    .prog_clk(clk), .prog_rst_n(rst_n), .start(start_b), .cfg_data(data_b),
    .cfg_valid(valid_b), .cfg_ready(ready_b), .ccff_head(head_b), .ccff_shift_en(sh_b),
    .ccff_tail(tail_b), .IO_ISOL_N(isol_b), .busy(busy_b), .done(done_b), .err(err_b),
    .tail_parity(par_b)
  );

  // Chain model: bit 0 is the tail, new bits enter at the top, so a fully
  // loaded chain reads back as the bitstream in LSB-first order.
  assign tail_a = chain_a[0];
  assign tail_b = chain_b[0];
  always @(posedge clk) begin
    if (preload_req)
      chain_a <= preload_val;
    else if (sh_a)
      chain_a <= {head_a, chain_a[79:1]};
    if (sh_b)
      chain_b <= {head_b, chain_b[19:1]};
  end

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One pass on dut_a; words 1,2,3,... are offered, with an optional stall of
  // stall_len LOAD cycles once stall_at words have been accepted.
  task automatic pass_a(input int stall_at, input int stall_len, input bit pulse_start,
                        output int n_cyc, output int n_words);
    int st;
    bit early;
    st = 0; early = 0; n_cyc = 0; n_words = 0;
    data_a = 8'd1; valid_a = 1'b1; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    while (!done_a && !err_a && n_cyc < 1000) begin
      n_cyc++;
      if (isol_a) early = 1'b1;
      valid_a = !(n_words == stall_at && ready_a && st < stall_len);
      if (!valid_a) st++;
      data_a  = 8'(n_words + 1);
      start_a = pulse_start && sh_a && (n_cyc % 5 == 0);
      if (ready_a && valid_a) n_words++;
      @(negedge clk);
    end
    start_a = 1'b0; valid_a = 1'b0;
    check("pass_bound", {79'd0, n_cyc < 1000}, 80'd1);
    check("isol_before_done", {79'd0, early}, 80'd0);
  endtask

  initial begin
    rst_n = 1'b0; preload_req = 1'b0; preload_val = '0;
    start_a = 0; valid_a = 0; data_a = '0;
    start_b = 0; valid_b = 0; data_b = '0;
    repeat (3) @(negedge clk);
    check("reset_a", {72'd0, ready_a, head_a, sh_a, isol_a, busy_a, done_a, err_a, par_a}, 80'd0);
    check("reset_b", {72'd0, ready_b, head_b, sh_b, isol_b, busy_b, done_b, err_b, par_b}, 80'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full default pass, valid always high
    pass_a(-1, 0, 1'b0, cyc, words);
    check("full_cycles", 80'(cyc), 80'd94);
    check("full_words", 80'(words), 80'd10);
    check("full_done", {78'd0, done_a, isol_a}, 80'b11);
    check("full_chain", chain_a, STREAM);
    check("full_parity", {79'd0, par_a}, 80'd0);
    repeat (3) @(negedge clk);
    check("done_hold", {77'd0, done_a, isol_a, busy_a}, 80'b110);

    // Short chain with a truncated last word
    data_b = 8'hFF; valid_b = 1'b1; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0; cyc = 0; words = 0; pulses = 0;
    while (!done_b && cyc < 200) begin
      cyc++;
      if (sh_b) pulses++;
      data_b = (words < 2) ? 8'hFF : 8'hA5;
      if (ready_b && valid_b) words++;
      @(negedge clk);
    end
    valid_b = 1'b0;
    check("short_cycles", 80'(cyc), 80'd23);
    check("short_words", 80'(words), 80'd3);
    check("short_pulses", 80'(pulses), 80'd20);
    check("short_chain", {60'd0, chain_b}, 80'h5FFFF);
    check("short_done", {78'd0, done_b, isol_b}, 80'b11);

    // 255-cycle stall after the third word times out
    pass_a(3, 255, 1'b0, cyc, words);
    check("to_err", {77'd0, err_a, done_a, isol_a}, 80'b100);
    check("to_words", 80'(words), 80'd3);
    check("to_cycles", 80'(cyc), 80'd282);
    repeat (4) @(negedge clk);
    check("err_hold", {78'd0, err_a, isol_a}, 80'b10);

    // Recovery from ERR with a full stream
    pass_a(-1, 0, 1'b0, cyc, words);
    check("recover_done", {78'd0, done_a, err_a}, 80'b10);
    check("recover_cycles", 80'(cyc), 80'd94);
    check("recover_chain", chain_a, STREAM);

    // 254-cycle stall is tolerated
    pass_a(3, 254, 1'b0, cyc, words);
    check("stall254_done", {78'd0, done_a, err_a}, 80'b10);
    check("stall254_cycles", 80'(cyc), 80'd348);
    check("stall254_words", 80'(words), 80'd10);

    // Preloaded chain with five ones; start pulses during SHIFT are ignored
    preload_val = 80'h1F000; preload_req = 1'b1;
    @(negedge clk);
    preload_req = 1'b0;
    pass_a(-1, 0, 1'b1, cyc, words);
    check("parity_value", {79'd0, par_a}, 80'd1);
    check("parity_cycles", 80'(cyc), 80'd94);
    check("parity_chain", chain_a, STREAM);

    // Reset pulse in the middle of SHIFT
    data_a = 8'h3C; valid_a = 1'b1; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int k = 0; k < 20 && !sh_a; k++) @(negedge clk);
    check("reach_shift", {79'd0, sh_a}, 80'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_a", {72'd0, ready_a, head_a, sh_a, isol_a, busy_a, done_a, err_a, par_a}, 80'd0);
    rst_n = 1'b1; valid_a = 1'b0;
    @(negedge clk);
    check("after_reset_idle", {77'd0, ready_a, busy_a, isol_a}, 80'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
